hdlc_rx_deframer: RTL

Serial HDLC receive front end. It samples the raw Rx bit stream and performs flag detection (0x7E), abort detection (7 consecutive ones) and zero-bit (stuffing) removal. It assembles de-stuffed bits into bytes, LSB first, and marks frame boundaries and errors. It feeds the Rx buffer/FCS stage with bytes plus Rx_ValidFrame, Rx_EoF, Rx_FrameError, Rx_FlagDetect and Rx_AbortDetect.

---
 rtl/hdlc_rx_deframer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero-bit removal and LSB-first
// byte assembly, with frame boundary, error and overflow marking.
module hdlc_rx_deframer #(
   parameter int MIN_BYTES = 4,
   parameter int MAX_BYTES = 128
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       RxEN,
   output logic [7:0] RxData,
   output logic       RxByteValid,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic       Rx_Overflow
);

   localparam int BCW = $clog2(MAX_BYTES + 2);
   localparam logic [BCW-1:0] BC_MAX = BCW'(MAX_BYTES);
   localparam logic [BCW-1:0] BC_MIN = BCW'(MIN_BYTES);

   typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_t;

   state_t         state, state_mid;
   logic [7:0]     win, win_new;
   logic [3:0]     win_cnt;
   logic [2:0]     in_ones, ex_ones;
   logic [2:0]     bit_cnt, bit_cnt_nx;
   logic [7:0]     shreg, shreg_nx;
   logic [BCW-1:0] byte_cnt, byte_cnt_nx;
   logic           flag, exit_valid, exit_bit, stuff_drop, stuff_abort;
   logic           data_valid, byte_done, emit, overflow, abort_evt;

   // NOTE: the exiting bit is resolved combinationally first, so the flag/abort
   // decision in the register block already sees the byte it may complete.
   always_comb begin
      win_new     = {Rx, win[7:1]};
      flag        = (win_new == 8'h7E);
      exit_bit    = win[0];
      exit_valid  = RxEN && (win_cnt == 4'd8) && (state != HUNT);
      stuff_drop  = exit_valid && (ex_ones == 3'd5) && !exit_bit;
      stuff_abort = exit_valid && (ex_ones == 3'd5) && exit_bit;
      data_valid  = exit_valid && (ex_ones != 3'd5);
      shreg_nx    = data_valid ? {exit_bit, shreg[7:1]} : shreg;
      bit_cnt_nx  = data_valid ? bit_cnt + 3'd1 : bit_cnt;
      byte_done   = data_valid && (bit_cnt == 3'd7);
      emit        = byte_done && (byte_cnt < BC_MAX);
      overflow    = byte_done && (byte_cnt == BC_MAX);
      byte_cnt_nx = (byte_done && (byte_cnt <= BC_MAX)) ? byte_cnt + BCW'(1) : byte_cnt;
      state_mid   = (state == SYNC && data_valid) ? FRAME : state;
      abort_evt   = (Rx && (in_ones == 3'd6)) || stuff_abort;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state          <= HUNT;
         win            <= '0;
         win_cnt        <= '0;
         in_ones        <= '0;
         ex_ones        <= '0;
         bit_cnt        <= '0;
         byte_cnt       <= '0;
         shreg          <= '0;
         RxData         <= '0;
         RxByteValid    <= 1'b0;
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortDetect <= 1'b0;
         Rx_ValidFrame  <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_Overflow    <= 1'b0;
      end else begin
         RxByteValid    <= 1'b0;
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortDetect <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_Overflow    <= 1'b0;
         if (RxEN) begin
            win      <= win_new;
            win_cnt  <= flag ? 4'd0 : ((win_cnt == 4'd8) ? 4'd8 : win_cnt + 4'd1);
            in_ones  <= !Rx ? 3'd0 : ((in_ones == 3'd7) ? 3'd7 : in_ones + 3'd1);
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            byte_cnt <= byte_cnt_nx;
            if (stuff_drop)
               ex_ones <= 3'd0;
            else if (data_valid)
               ex_ones <= exit_bit ? ex_ones + 3'd1 : 3'd0;
            if (emit) begin
               RxData      <= shreg_nx;
               RxByteValid <= 1'b1;
            end
            Rx_Overflow <= overflow;
            state       <= state_mid;

            // A flag always resynchronises; if a frame was open it also closes it.
            if (flag) begin
               Rx_FlagDetect <= 1'b1;
               Rx_ValidFrame <= 1'b0;
               state         <= SYNC;
               ex_ones       <= 3'd0;
               bit_cnt       <= 3'd0;
               byte_cnt      <= '0;
               if (state_mid == FRAME) begin
                  Rx_EoF        <= 1'b1;
                  Rx_FrameError <= (bit_cnt_nx != 3'd0) || (byte_cnt_nx < BC_MIN) ||
                                   (byte_cnt_nx > BC_MAX);
               end
            end else if (abort_evt && (state_mid != HUNT)) begin
               Rx_AbortDetect <= (state_mid == FRAME);
               Rx_ValidFrame  <= 1'b0;
               state          <= HUNT;
            end else if (state_mid == FRAME) begin
               Rx_ValidFrame <= 1'b1;
            end
         end
      end
   end

endmodule
